// File: rtl/thor2021_decode_queue.sv
// Thor2021 decode queue: buffers fetched words, fuses an EXI7/EXI23/EXI41
// postfix into the preceding immediate-capable instruction, and presents one
// registered decoded bundle per ready/valid handshake.
//
// Opcode map (ir[6:0]) understood by this stage:
//   02 R-type | 04..07 ADDI,SUBFI,MULI,SLTI | 08 ANDI | 09 ORI | 0A XORI
//   0B CHKI   | 14..17 ADDIL..SLTIL | 18 ANDIL | 19 ORIL | 1A XORIL
//   20 JMP    | 28..2F branches | 46 EXI7 | 48 EXI23 | 50 EXI41
//   60..67 loads | 70..77 stores
module thor2021_decode_queue #(
    parameter int DEPTH      = 8,
    parameter int IW         = 48,
    parameter int AW         = 32,
    parameter int PF_TIMEOUT = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   fetch_valid_i,
    input  logic [IW-1:0]          fetch_ir_i,
    input  logic [AW-1:0]          fetch_pc_i,
    output logic                   fetch_ready_o,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output logic [IW-1:0]          dec_ir_o,
    output logic [AW-1:0]          dec_pc_o,
    output logic [63:0]            dec_imm_o,
    output logic                   dec_ext_o,
    output logic                   dec_orphan_o,
    output logic [5:0]             dec_ra_o,
    output logic [5:0]             dec_rb_o,
    output logic [5:0]             dec_rc_o,
    output logic [5:0]             dec_rt_o,
    output logic                   dec_rfwr_o,
    output logic                   dec_ld_o,
    output logic                   dec_st_o,
    output logic                   dec_jxx_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(PF_TIMEOUT + 1);

    localparam logic [6:0] OP_R     = 7'h02;
    localparam logic [6:0] OP_ADDI  = 7'h04;
    localparam logic [6:0] OP_SLTI  = 7'h07;
    localparam logic [6:0] OP_ANDI  = 7'h08;
    localparam logic [6:0] OP_ORI   = 7'h09;
    localparam logic [6:0] OP_XORI  = 7'h0A;
    localparam logic [6:0] OP_CHKI  = 7'h0B;
    localparam logic [6:0] OP_ADDIL = 7'h14;
    localparam logic [6:0] OP_SLTIL = 7'h17;
    localparam logic [6:0] OP_ANDIL = 7'h18;
    localparam logic [6:0] OP_ORIL  = 7'h19;
    localparam logic [6:0] OP_XORIL = 7'h1A;
    localparam logic [6:0] OP_JMP   = 7'h20;
    localparam logic [6:0] OP_EXI7  = 7'h46;
    localparam logic [6:0] OP_EXI23 = 7'h48;
    localparam logic [6:0] OP_EXI41 = 7'h50;

    typedef enum logic [1:0] {S_EMPTY, S_RUN, S_WAIT} state_t;

    typedef struct packed {
        logic [IW-1:0] ir;
        logic [AW-1:0] pc;
        logic [63:0]   imm;
        logic          ext;
        logic          orphan;
        logic [5:0]    ra, rb, rc, rt;
        logic          rfwr, ld, st, jxx;
    } bundle_t;

    function automatic logic imm_cap(input logic [6:0] op);
        return (op >= OP_ADDI && op <= OP_CHKI) || (op >= OP_ADDIL && op <= OP_XORIL);
    endfunction

    function automatic logic is_pfx(input logic [6:0] op);
        return op == OP_EXI7 || op == OP_EXI23 || op == OP_EXI41;
    endfunction

    // Build a bundle from head word i and (when fused) its postfix x.
    function automatic bundle_t decode(input logic [IW-1:0] i, input logic [IW-1:0] x,
                                       input logic [AW-1:0] pc, input logic fuse);
        bundle_t    b;
        logic [6:0] op;
        logic       orphan, ld, st, jxx;
        op     = i[6:0];
        b      = '0;
        orphan = is_pfx(op);
        ld     = op[6:3] == 4'b1100;
        st     = op[6:3] == 4'b1110;
        jxx    = op == OP_JMP || op[6:3] == 4'b0101;
        b.ir     = i;
        b.pc     = pc;
        b.ext    = fuse;
        b.orphan = orphan;
        b.ra     = i[20:15];
        b.rb     = i[26:21];
        b.rc     = st  ? i[14:9] : i[34:29];
        b.rt     = jxx ? {4'd0, i[10:9]} : i[14:9];
        // A postfix with nothing to attach to issues as an inert bubble.
        if (!orphan) begin
            b.ld   = ld;
            b.st   = st;
            b.jxx  = jxx;
            b.rfwr = op == OP_R || ld || (imm_cap(op) && op != OP_CHKI);
            if (op >= OP_ADDI && op <= OP_SLTI)          b.imm = {{53{i[19]}}, i[19:9]};
            else if (op == OP_ANDI)                      b.imm = {{53{1'b1}}, i[19:9]};
            else if (op == OP_ORI || op == OP_XORI)      b.imm = {53'd0, i[19:9]};
            else if (op == OP_CHKI)                      b.imm = {{42{i[47]}}, i[47:29], i[11:9]};
            else if (op >= OP_ADDIL && op <= OP_SLTIL)   b.imm = {{41{i[43]}}, i[43:21]};
            else if (op == OP_ANDIL)                     b.imm = {{41{1'b1}}, i[43:21]};
            else if (op == OP_ORIL || op == OP_XORIL)    b.imm = {41'd0, i[43:21]};
            if (fuse) begin
                if (x[6:0] == OP_EXI7)       b.imm = {{34{x[15]}}, x[15:9], i[43:21]};
                else if (x[6:0] == OP_EXI23) b.imm = {{18{x[31]}}, x[31:9], i[43:21]};
                else                         b.imm = {x[47:9], i[43:21], x[1:0]};
            end
        end
        return b;
    endfunction

    logic [IW-1:0] ir_q [DEPTH];
    logic [AW-1:0] pc_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, nx_ptr;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    state_t        state_q, state_d;
    logic [IW-1:0] head_ir, next_ir;
    logic          head_cap, fuse, issuable, load, push, waiting;
    logic [1:0]    pop_n;
    logic          dec_valid_q;
    bundle_t       bun_q, bun_d;

    assign fetch_ready_o = count_q < CW'(DEPTH);
    assign count_o       = count_q;

    // Head inspection, issue decision, occupancy and postfix-wait bookkeeping.
    always_comb begin
        nx_ptr   = rd_ptr_q + PW'(1);
        head_ir  = ir_q[rd_ptr_q];
        next_ir  = ir_q[nx_ptr];
        head_cap = imm_cap(head_ir[6:0]);
        fuse     = (count_q >= CW'(2)) && head_cap && is_pfx(next_ir[6:0]);
        issuable = (count_q >= CW'(2)) ||
                   (count_q == CW'(1) && (!head_cap ||
                    (state_q == S_WAIT && timer_q == TW'(PF_TIMEOUT))));
        load     = (!dec_valid_q || dec_ready_i) && issuable;
        pop_n    = load ? (fuse ? 2'd2 : 2'd1) : 2'd0;
        push     = fetch_valid_i && fetch_ready_o && !flush_i;
        count_d  = count_q + CW'(push) - CW'(pop_n);
        waiting  = count_q == CW'(1) && head_cap && !push && !load;
        bun_d    = decode(head_ir, next_ir, pc_q[rd_ptr_q], fuse);
    end

    // Next state: a lone imm-capable head starts the postfix wait; any push
    // or issue leaves it and clears the timer.
    always_comb begin
        state_d = S_RUN;
        timer_d = '0;
        if (count_d == '0) begin
            state_d = S_EMPTY;
        end else if (waiting) begin
            state_d = S_WAIT;
            timer_d = (timer_q == TW'(PF_TIMEOUT)) ? timer_q : timer_q + TW'(1);
        end
    end

    // Queue pointers, occupancy, wait timer and state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            state_q  <= S_EMPTY;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            state_q  <= S_EMPTY;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            rd_ptr_q <= rd_ptr_q + PW'(pop_n);
            count_q  <= count_d;
            timer_q  <= timer_d;
            state_q  <= state_d;
        end
    end

    // Entry storage; contents are meaningless outside the count window.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ir_q[wr_ptr_q] <= fetch_ir_i;
            pc_q[wr_ptr_q] <= fetch_pc_i;
        end
    end

    // Output register: load on a free slot, hold while stalled, drop when taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_valid_q <= 1'b0;
            bun_q       <= '0;
        end else if (flush_i) begin
            dec_valid_q <= 1'b0;
            bun_q       <= '0;
        end else if (load) begin
            dec_valid_q <= 1'b1;
            bun_q       <= bun_d;
        end else if (dec_ready_i) begin
            dec_valid_q <= 1'b0;
        end
    end

    assign dec_valid_o  = dec_valid_q;
    assign dec_ir_o     = bun_q.ir;
    assign dec_pc_o     = bun_q.pc;
    assign dec_imm_o    = bun_q.imm;
    assign dec_ext_o    = bun_q.ext;
    assign dec_orphan_o = bun_q.orphan;
    assign dec_ra_o     = bun_q.ra;
    assign dec_rb_o     = bun_q.rb;
    assign dec_rc_o     = bun_q.rc;
    assign dec_rt_o     = bun_q.rt;
    assign dec_rfwr_o   = bun_q.rfwr;
    assign dec_ld_o     = bun_q.ld;
    assign dec_st_o     = bun_q.st;
    assign dec_jxx_o    = bun_q.jxx;

endmodule

// File: tb/tb_thor2021_decode_queue.sv
// Directed bench for thor2021_decode_queue: hand-computed expected bundles.
module tb_thor2021_decode_queue;
    localparam int DEPTH = 8;
    localparam int IW    = 48;
    localparam int AW    = 32;
    localparam int PFT   = 15;

    localparam logic [6:0] OP_R = 7'h02, OP_ADDI = 7'h04, OP_ANDI = 7'h08, OP_ADDIL = 7'h14;
    localparam logic [6:0] OP_BR = 7'h28, OP_EXI7 = 7'h46, OP_EXI23 = 7'h48, OP_EXI41 = 7'h50;
    localparam logic [6:0] OP_LD = 7'h60, OP_ST = 7'h70;

    logic          clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
    logic          fetch_valid_i = 1'b0, dec_ready_i = 1'b0;
    logic [IW-1:0] fetch_ir_i = '0;
    logic [AW-1:0] fetch_pc_i = '0;
    logic          fetch_ready_o, dec_valid_o, dec_ext_o, dec_orphan_o;
    logic [IW-1:0] dec_ir_o;
    logic [AW-1:0] dec_pc_o;
    logic [63:0]   dec_imm_o;
    logic [5:0]    dec_ra_o, dec_rb_o, dec_rc_o, dec_rt_o;
    logic          dec_rfwr_o, dec_ld_o, dec_st_o, dec_jxx_o;
    logic [3:0]    count_o;

    int total = 0, bad = 0, npush = 0;

    thor2021_decode_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW), .PF_TIMEOUT(PFT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ir_i(fetch_ir_i), .fetch_pc_i(fetch_pc_i),
        .fetch_ready_o(fetch_ready_o), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_ir_o(dec_ir_o), .dec_pc_o(dec_pc_o), .dec_imm_o(dec_imm_o),
        .dec_ext_o(dec_ext_o), .dec_orphan_o(dec_orphan_o),
        .dec_ra_o(dec_ra_o), .dec_rb_o(dec_rb_o), .dec_rc_o(dec_rc_o), .dec_rt_o(dec_rt_o),
        .dec_rfwr_o(dec_rfwr_o), .dec_ld_o(dec_ld_o), .dec_st_o(dec_st_o), .dec_jxx_o(dec_jxx_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] ir, input logic [AW-1:0] pc);
        fetch_valid_i = 1'b1;
        fetch_ir_i    = ir;
        fetch_pc_i    = pc;
        tick();
        fetch_valid_i = 1'b0;
        npush++;
    endtask

    function automatic logic [IW-1:0] mk(input logic [6:0] op, input logic [5:0] rt, input logic [5:0] ra);
        logic [IW-1:0] r;
        r        = '0;
        r[6:0]   = op;
        r[14:9]  = rt;
        r[20:15] = ra;
        return r;
    endfunction

    initial begin
        logic [IW-1:0] w, x;
        int n;

        // reset state
        tick();
        tick();
        chk("rst_count", count_o, 0);
        chk("rst_valid", dec_valid_o, 0);
        chk("rst_ready", fetch_ready_o, 1);
        chk("rst_imm", dec_imm_o, 0);
        rst_ni = 1'b1;
        tick();

        // ADDIL + EXI7 fused
        dec_ready_i = 1'b1;
        w = mk(OP_ADDIL, 6'd5, 6'd3);
        w[43:21] = 23'h400000;
        x = mk(OP_EXI7, 6'd0, 6'd0);
        x[15:9] = 7'h7F;
        push(w, 32'h100);
        chk("f7_cnt1", count_o, 1);
        push(x, 32'h106);
        tick();
        chk("f7_valid", dec_valid_o, 1);
        chk("f7_ext", dec_ext_o, 1);
        chk("f7_imm", dec_imm_o, 64'hFFFF_FFFF_FFC0_0000);
        chk("f7_pc", dec_pc_o, 32'h100);
        chk("f7_rt", dec_rt_o, 5);
        chk("f7_ra", dec_ra_o, 3);
        chk("f7_rfwr", dec_rfwr_o, 1);
        chk("f7_cnt0", count_o, 0);
        tick();
        chk("f7_taken", dec_valid_o, 0);

        // lone ADDI waits for postfix timeout
        w = mk(OP_ADDI, 6'd0, 6'd0);
        w[19:9] = 11'h400;
        push(w, 32'h120);
        n = 0;
        while (!dec_valid_o && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", n, PFT + 1);
        chk("to_ext", dec_ext_o, 0);
        chk("to_imm", dec_imm_o, 64'hFFFF_FFFF_FFFF_FC00);
        chk("to_pc", dec_pc_o, 32'h120);
        tick();

        // fill to full with output stalled
        dec_ready_i = 1'b0;
        for (int k = 0; k < 9; k++) push(mk(OP_R, 6'(k), 6'd0), 32'h200 + 32'(6 * k));
        chk("full_cnt", count_o, 8);
        chk("full_ready", fetch_ready_o, 0);
        chk("full_valid", dec_valid_o, 1);
        chk("full_pc", dec_pc_o, 32'h200);
        fetch_valid_i = 1'b1;
        fetch_ir_i    = mk(OP_R, 6'd9, 6'd0);
        tick();
        chk("full_refuse", count_o, 8);
        chk("full_stable", dec_pc_o, 32'h200);
        chk("full_stable_ir", dec_ir_o, mk(OP_R, 6'd0, 6'd0));
        dec_ready_i = 1'b1;
        tick();
        fetch_valid_i = 1'b0;
        chk("full_pop_nopush", count_o, 7);
        chk("full_pop_pc", dec_pc_o, 32'h206);
        repeat (8) tick();
        chk("drain_cnt", count_o, 0);
        chk("drain_valid", dec_valid_o, 0);

        // align write pointer to slot 7 so the pair straddles the wrap
        n = (7 - (npush % DEPTH) + DEPTH) % DEPTH;
        for (int k = 0; k < n; k++) push(mk(OP_R, 6'd1, 6'd1), 32'h280);
        repeat (3) tick();
        chk("align_cnt", count_o, 0);
        w = mk(OP_ADDIL, 6'd7, 6'd2);
        w[43:21] = 23'h123456;
        x = mk(OP_EXI23, 6'd0, 6'd0);
        x[31:9] = 23'h400001;
        push(w, 32'h300);
        push(x, 32'h306);
        tick();
        chk("wrap_ext", dec_ext_o, 1);
        chk("wrap_imm", dec_imm_o, 64'hFFFF_E000_0092_3456);
        chk("wrap_pc", dec_pc_o, 32'h300);
        chk("wrap_cnt", count_o, 0);

        // EXI41 fusion
        w = mk(OP_ADDIL, 6'd4, 6'd0);
        w[43:21] = 23'h000003;
        x = '0;
        x[6:0]  = OP_EXI41;
        x[47:9] = 39'h1;
        push(w, 32'h310);
        push(x, 32'h316);
        tick();
        chk("e41_ext", dec_ext_o, 1);
        chk("e41_imm", dec_imm_o, 64'h0000_0000_0200_000C);

        // orphan postfix
        x = mk(OP_EXI23, 6'd2, 6'd1);
        x[31:9] = 23'h7FFFFF;
        push(x, 32'h320);
        tick();
        chk("orph_valid", dec_valid_o, 1);
        chk("orph_flag", dec_orphan_o, 1);
        chk("orph_rfwr", dec_rfwr_o, 0);
        chk("orph_imm", dec_imm_o, 0);
        chk("orph_ext", dec_ext_o, 0);
        tick();

        // class decode stream: ANDI (not fused, next is R), R, branch, store, load
        w = mk(OP_ANDI, 6'd0, 6'd0);
        w[19:9] = 11'h001;
        push(w, 32'h400);
        push(mk(OP_R, 6'd11, 6'd12), 32'h406);
        push(mk(OP_BR, 6'h3E, 6'd1), 32'h40C);
        chk("andi_imm", dec_imm_o, 64'hFFFF_FFFF_FFFF_F801);
        chk("andi_ext", dec_ext_o, 0);
        w = mk(OP_ST, 6'd9, 6'd4);
        w[34:29] = 6'h2A;
        push(w, 32'h412);
        chk("r_rt", dec_rt_o, 11);
        chk("r_rfwr", dec_rfwr_o, 1);
        w = mk(OP_LD, 6'd8, 6'd4);
        w[34:29] = 6'h15;
        push(w, 32'h418);
        chk("br_rt", dec_rt_o, 2);
        chk("br_jxx", dec_jxx_o, 1);
        chk("br_rfwr", dec_rfwr_o, 0);
        tick();
        chk("st_rc", dec_rc_o, 9);
        chk("st_flag", dec_st_o, 1);
        tick();
        chk("ld_rc", dec_rc_o, 6'h15);
        chk("ld_flag", dec_ld_o, 1);
        chk("ld_rfwr", dec_rfwr_o, 1);
        tick();

        // flush mid-stream, with a push in the flush cycle
        dec_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) push(mk(OP_R, 6'd3, 6'd3), 32'h500 + 32'(k));
        chk("fl_pre_cnt", count_o, 2);
        flush_i       = 1'b1;
        fetch_valid_i = 1'b1;
        tick();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        chk("fl_cnt", count_o, 0);
        chk("fl_valid", dec_valid_o, 0);
        chk("fl_ready", fetch_ready_o, 1);
        tick();
        chk("fl_drop", count_o, 0);

        // async reset while waiting for a postfix
        push(mk(OP_R, 6'd1, 6'd1), 32'h600);
        push(mk(OP_ADDI, 6'd1, 6'd1), 32'h606);
        repeat (3) tick();
        chk("rw_pre_valid", dec_valid_o, 1);
        chk("rw_pre_cnt", count_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rw_valid", dec_valid_o, 0);
        chk("rw_cnt", count_o, 0);
        chk("rw_pc", dec_pc_o, 0);
        chk("rw_ready", fetch_ready_o, 1);
        tick();
        rst_ni      = 1'b1;
        dec_ready_i = 1'b1;
        repeat (PFT + 5) tick();
        chk("rw_post_valid", dec_valid_o, 0);
        chk("rw_post_cnt", count_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
